// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: register indices, FSM states, bus command.
package uart_tx_sched_pkg;

  localparam logic [2:0] UART_MUX_TDR  = 3'd0;
  localparam logic [2:0] UART_MUX_RDR  = 3'd1;
  localparam logic [2:0] UART_MUX_CTRL = 3'd2;
  localparam logic [2:0] UART_MUX_STAT = 3'd3;
  localparam logic [2:0] UART_MUX_BAUD = 3'd4;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_BAUD,
    ST_IDLE,
    ST_WR_TDR,
    ST_WR_CTRL,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_ABORT,
    ST_RX_RD
  } uts_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  reg_num;
    logic [31:0] wd;
  } uart_cmd_t;

  localparam uart_cmd_t CMD_POLL = '{we: 1'b0, reg_num: UART_MUX_STAT, wd: 32'h0};

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Two-input round-robin arbiter; the pointer remembers the last grantee and moves only on accept.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic       grant_idx,
  output logic       grant_vld
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_vld = |req_valid;
    grant_idx = (&req_valid) ? ~ptr_q : req_valid[1];
    ptr_d     = accept ? grant_idx : ptr_q;
  end

  // Pointer starts at 1 so requester 0 wins the first contended round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Bus master driving the UART register port: BAUD setup, round-robin byte sends, poll with timeout.
// Optional receive draining is compiled in with UART_SCHED_RX_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter logic [31:0] BAUD_DIV    = 32'd103,
  parameter int          TIMEOUT_CYC = 4096,
  parameter int          TO_W        = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        grant_id,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr,
  output logic        uart_we,
  output logic [2:0]  uart_reg_num,
  output logic [31:0] uart_wd,
  input  logic [31:0] uart_rd,
  output logic        rx_valid,
  output logic [7:0]  rx_data
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  uts_state_e      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            grant_id_q, grant_id_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            primed_q, primed_d;
  logic            err_q, err_d;
  uart_cmd_t       cmd_q, cmd_d;
  logic            accept;
  logic            rx_take;
  logic            grant_idx;
  logic            grant_vld;

  uart_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid ({req1_valid, req0_valid}),
    .accept    (accept),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

`ifdef UART_SCHED_RX_EN
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       unused_rd;
  assign unused_rd = ^uart_rd[30:8];
`else
  logic unused_rd;
  assign unused_rd = ^uart_rd[31:1];
`endif

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    grant_id_d = grant_id_q;
    to_cnt_d   = to_cnt_q;
    accept     = 1'b0;
    rx_take    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef UART_SCHED_RX_EN
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
`endif
    case (state_q)
      ST_INIT:    state_d = ST_BAUD;
      ST_BAUD:    state_d = ST_IDLE;
      ST_IDLE: begin
`ifdef UART_SCHED_RX_EN
        rx_take = primed_q & uart_rd[31];
`endif
        if (rx_take) begin
          state_d = ST_RX_RD;
        end else if (grant_vld) begin
          accept     = 1'b1;
          req0_ready = ~grant_idx;
          req1_ready = grant_idx;
          byte_d     = grant_idx ? req1_data : req0_data;
          grant_id_d = grant_idx;
          state_d    = ST_WR_TDR;
        end
      end
      ST_WR_TDR:  state_d = ST_WR_CTRL;
      ST_WR_CTRL: begin
        state_d  = ST_WAIT_START;
        to_cnt_d = '0;
      end
      // Success is checked before the timeout so a late but valid status still counts.
      ST_WAIT_START: begin
        if (primed_q && uart_rd[0]) begin
          state_d  = ST_WAIT_END;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
          state_d = ST_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_END: begin
        if (primed_q && !uart_rd[0]) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_MAX) begin
          state_d = ST_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ABORT:   state_d = ST_IDLE;
`ifdef UART_SCHED_RX_EN
      ST_RX_RD: begin
        if (primed_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = uart_rd[7:0];
          state_d    = ST_IDLE;
        end
      end
`endif
      default:    state_d = ST_INIT;
    endcase
  end

  // Bus command is decoded from the next state so the registered port lines up with state_q.
  always_comb begin
    cmd_d = CMD_POLL;
    case (state_d)
      ST_BAUD:    cmd_d = '{we: 1'b1, reg_num: UART_MUX_BAUD, wd: BAUD_DIV};
      ST_WR_TDR:  cmd_d = '{we: 1'b1, reg_num: UART_MUX_TDR,  wd: {24'h0, byte_d}};
      ST_WR_CTRL: cmd_d = '{we: 1'b1, reg_num: UART_MUX_CTRL, wd: 32'h1};
      ST_ABORT:   cmd_d = '{we: 1'b1, reg_num: UART_MUX_CTRL, wd: 32'h0};
      ST_RX_RD:   cmd_d = '{we: 1'b0, reg_num: UART_MUX_RDR,  wd: 32'h0};
      default:    cmd_d = CMD_POLL;
    endcase
    primed_d = (cmd_d.reg_num == cmd_q.reg_num);
    err_d    = (state_d == ST_ABORT) ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      byte_q     <= '0;
      grant_id_q <= 1'b0;
      to_cnt_q   <= '0;
      primed_q   <= 1'b0;
      err_q      <= 1'b0;
      cmd_q      <= CMD_POLL;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      grant_id_q <= grant_id_d;
      to_cnt_q   <= to_cnt_d;
      primed_q   <= primed_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
    end
  end

`ifdef UART_SCHED_RX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_valid = 1'b0;
  assign rx_data  = 8'h0;
`endif

  assign grant_id     = grant_id_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_timeout  = err_q;
  assign uart_we      = cmd_q.we;
  assign uart_reg_num = cmd_q.reg_num;
  assign uart_wd      = cmd_q.wd;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small registered UART model; second instance uses a short timeout.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        grant_id, busy, err_timeout, err_clr;
  logic        uart_we;
  logic [2:0]  uart_reg_num;
  logic [31:0] uart_wd;
  logic [31:0] uart_rd;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        b_req0_valid;
  logic [7:0]  b_req0_data;
  logic        b_req0_ready, b_req1_ready, b_grant_id, b_busy, b_err, b_err_clr;
  logic        b_we, b_rx_valid;
  logic [2:0]  b_reg;
  logic [31:0] b_wd;
  logic [7:0]  b_rx_data;

  int n_checks = 0;
  int n_errors = 0;

  // UART model state
  int   cyc = 0;
  int   clr_cyc = 0;
  int   set_dly = 10;
  int   clr_dly = 100;
  int   tx_cnt = 0;
  logic tx_run = 1'b0;
  logic stat0 = 1'b0;
  logic rx_ne = 1'b0;
  logic rx_push = 1'b0;

  uart_tx_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
    .uart_we(uart_we), .uart_reg_num(uart_reg_num), .uart_wd(uart_wd), .uart_rd(uart_rd),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  uart_tx_sched #(.TIMEOUT_CYC(16), .TO_W(5)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(b_req1_ready),
    .grant_id(b_grant_id), .busy(b_busy), .err_timeout(b_err), .err_clr(b_err_clr),
    .uart_we(b_we), .uart_reg_num(b_reg), .uart_wd(b_wd), .uart_rd(32'h0),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      tx_run <= 1'b0;
      stat0  <= 1'b0;
    end else if (uart_we && uart_reg_num == UART_MUX_CTRL && uart_wd == 32'h1) begin
      tx_run <= 1'b1;
      tx_cnt <= 0;
    end else if (tx_run) begin
      tx_cnt <= tx_cnt + 1;
      if (tx_cnt + 1 == set_dly) stat0 <= 1'b1;
      if (tx_cnt + 1 == set_dly + clr_dly) begin
        stat0   <= 1'b0;
        tx_run  <= 1'b0;
        clr_cyc <= cyc;
      end
    end
    if (rx_push) rx_ne <= 1'b1;
    else if (uart_reg_num == UART_MUX_RDR) rx_ne <= 1'b0;
    case (uart_reg_num)
      UART_MUX_STAT: uart_rd <= {rx_ne, 30'h0, stat0};
      UART_MUX_RDR:  uart_rd <= 32'h0000_00A5;
      default:       uart_rd <= 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n0, n1, nacc, pend;
    logic [7:0] pend_byte;
    logic found;
    rst_n = 1'b0; err_clr = 1'b0; b_err_clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h0; req1_data = 8'h0;
    b_req0_valid = 1'b0; b_req0_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_we", uart_we, 0);
    check("rst_reg", uart_reg_num, UART_MUX_STAT);
    check("rst_wd", uart_wd, 0);
    check("rst_gid", grant_id, 0);
    check("rst_err", err_timeout, 0);
    check("rst_rxv", rx_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("init_we", uart_we, 0); check("init_busy", busy, 1);
    @(negedge clk); check("baud_we", uart_we, 1); check("baud_reg", uart_reg_num, UART_MUX_BAUD);
    check("baud_wd", uart_wd, 103);
    @(negedge clk); check("idle_busy", busy, 0); check("idle_reg", uart_reg_num, UART_MUX_STAT);

    // single byte from requester 0
    req0_valid = 1'b1; req0_data = 8'h55; #1;
    check("tx_ready0", req0_ready, 1); check("tx_ready1", req1_ready, 0);
    @(negedge clk); req0_valid = 1'b0;
    check("tx_tdr_we", uart_we, 1); check("tx_tdr_reg", uart_reg_num, UART_MUX_TDR);
    check("tx_tdr_wd", uart_wd, 32'h55); check("tx_gid", grant_id, 0); check("tx_busy", busy, 1);
    @(negedge clk); check("tx_ctrl_reg", uart_reg_num, UART_MUX_CTRL); check("tx_ctrl_wd", uart_wd, 1);
    @(negedge clk); check("tx_poll_we", uart_we, 0); check("tx_poll_reg", uart_reg_num, UART_MUX_STAT);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("tx_done_seen", found, 1);
    check("tx_done_lat", cyc - clr_cyc, 3);

    // round robin with both requesters held valid
    set_dly = 2; clr_dly = 3;
    req0_data = 8'hA0; req1_data = 8'hB0; req0_valid = 1'b1; req1_valid = 1'b1;
    n0 = 0; n1 = 0; nacc = 0; pend = -1; pend_byte = 8'h0;
    for (int c = 0; c < 3000 && (n0 < 4 || n1 < 4 || pend >= 0); c++) begin
      @(negedge clk);
      if (pend >= 0) begin
        check("rr_gid", grant_id, pend);
        check("rr_tdr", uart_wd, {24'h0, pend_byte});
        if (pend == 0) begin n0++; req0_data++; if (n0 == 4) req0_valid = 1'b0; end
        else begin n1++; req1_data++; if (n1 == 4) req1_valid = 1'b0; end
        pend = -1;
      end
      #1;
      if (req0_valid && req0_ready) begin
        check("rr_order", 0, nacc % 2); pend = 0; pend_byte = req0_data; nacc++;
      end else if (req1_valid && req1_ready) begin
        check("rr_order", 1, nacc % 2); pend = 1; pend_byte = req1_data; nacc++;
      end
    end
    check("rr_count", nacc, 8);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("rr_idle", found, 1);

    // poll timeout on the short-timeout instance
    b_req0_valid = 1'b1; b_req0_data = 8'h77; #1;
    check("to_ready", b_req0_ready, 1);
    @(negedge clk); b_req0_valid = 1'b0;
    check("to_tdr_wd", b_wd, 32'h77);
    @(negedge clk); check("to_ctrl_wd", b_wd, 1);
    k = 0; found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk); k++;
      if (b_we && b_reg == UART_MUX_CTRL && b_wd == 32'h0) found = 1'b1;
    end
    check("to_abort_seen", found, 1);
    check("to_abort_lat", k, 17);
    check("to_err_set", b_err, 1);
    @(negedge clk); check("to_idle", b_busy, 0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", b_err, 1); check("to_no_retry", b_busy, 0);
    b_err_clr = 1'b1;
    @(negedge clk); b_err_clr = 1'b0;
    check("to_err_clr", b_err, 0);

    // reset in the middle of WAIT_END
    set_dly = 10; clr_dly = 100;
    req1_valid = 1'b1; req1_data = 8'h3C; #1;
    check("mid_ready1", req1_ready, 1);
    @(negedge clk); req1_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (stat0) found = 1'b1;
    end
    check("mid_stat_seen", found, 1);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1); check("mid_gid", grant_id, 1);
    #2 rst_n = 1'b0; #1;
    check("mid_rst_we", uart_we, 0); check("mid_rst_reg", uart_reg_num, UART_MUX_STAT);
    check("mid_rst_gid", grant_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("mid_init_we", uart_we, 0);
    @(negedge clk); check("mid_baud_reg", uart_reg_num, UART_MUX_BAUD); check("mid_baud_wd", uart_wd, 103);
    @(negedge clk); check("mid_idle", busy, 0);

`ifdef UART_SCHED_RX_EN
    // receive drain takes priority over a pending transmit
    repeat (2) @(negedge clk);
    rx_push = 1'b1;
    @(negedge clk); rx_push = 1'b0;
    @(negedge clk); req1_valid = 1'b1; req1_data = 8'h3C; #1;
    check("rx_block_ready", req1_ready, 0);
    k = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); k++;
      if (rx_valid) found = 1'b1;
    end
    check("rx_seen", found, 1); check("rx_lat", k, 3); check("rx_data", rx_data, 8'hA5);
    @(negedge clk); req1_valid = 1'b0;
    check("rx_pulse", rx_valid, 0);
    check("rx_tx_reg", uart_reg_num, UART_MUX_TDR); check("rx_tx_wd", uart_wd, 32'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
